adc_trig_capture: RTL and testbench
===================================

ADC_TRIG_CAPTURE -- requirements
Module: adc_trig_capture

Interface
REQ-001 SHALL have parameters: DATA_W, default 8, ADC sample width; ADDR_W, default 10, capture-buffer address width (DEPTH = 2^ADDR_W).
REQ-002 SHALL have ports:
- clkin  in  1  ADC sample clock from the ADC PLL; the only clock.
- reset  in  1  synchronous, active-high reset.
- adc_data  in  DATA_W  ADC parallel output, one sample per clkin.
- arm  in  1  one-cycle start request.
- force_trig  in  1  immediate trigger.
- trig_edge  in  1  0 = rising, 1 = falling.
- trig_level  in  DATA_W  unsigned threshold.
- pre_len  in  ADDR_W  pre-trigger sample count.
- rd_ack  in  1  reader finished with buffer.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  ADDR_W  buffer write address.
- wr_data  out  DATA_W  buffer write data.
- trig_addr  out  ADDR_W  address of trigger sample.
- busy  out  1  capture in progress.
- done  out  1  buffer complete, awaiting rd_ack.
REQ-003 SHALL have one clock (clkin); reset SHALL be synchronous and active-high.

Function
REQ-004 SHALL implement states IDLE, PRE, WAIT_TRIG, POST, DONE.
REQ-005 IDLE: arm=1 -> PRE if pre_len>0, else WAIT_TRIG; sample index and write address reset to 0.
REQ-006 In PRE/WAIT_TRIG/POST every cycle's adc_data SHALL be written: wr_en, wr_addr, wr_data registered, valid the cycle after sampling (latency 1).
REQ-007 wr_addr SHALL increment by 1 per write, wrapping modulo DEPTH.
REQ-008 PRE SHALL write exactly pre_len samples, ignore triggers, then enter WAIT_TRIG.
REQ-009 Rising trigger: prev < trig_level and cur >= trig_level; falling: prev > trig_level and cur <= trig_level; unsigned compare; prev = previous sample of this capture.
REQ-010 First sample after arm SHALL NOT edge-trigger (no valid prev); force_trig may.
REQ-011 In WAIT_TRIG, edge or force_trig SHALL mark the current sample as trigger: trig_addr latched to its address, state -> POST.
REQ-012 POST SHALL write DEPTH - pre_len samples total including the trigger sample, then -> DONE; pre_len = DEPTH-1 yields exactly 1 post sample.
REQ-013 WAIT_TRIG SHALL wait indefinitely, overwriting circularly.
REQ-014 DONE: done=1, busy=0, wr_en=0; rd_ack -> IDLE next cycle.
REQ-015 busy SHALL be 1 in PRE, WAIT_TRIG, POST only.
REQ-016 arm SHALL be ignored outside IDLE, including same-cycle arm+rd_ack in DONE.
REQ-017 trig_addr SHALL hold until next trigger or reset; reader origin = trig_addr - pre_len mod DEPTH.

Reset
REQ-018 reset SHALL force IDLE next edge from any state, overriding all inputs.
REQ-019 Reset values: wr_en=0, wr_addr=0, wr_data=0, trig_addr=0, busy=0, done=0, prev-valid flag=0.

Structure
REQ-020 Shared package adc_cap_pkg SHALL hold the state enumeration and default DATA_W/ADDR_W constants.
REQ-021 Edge comparator SHALL be sub-module adc_trig_detect (prev/cur/level/edge in, hit out, combinational).
REQ-022 Buffer RAM SHALL be external; this block only drives write port.

Verification (DATA_W=8, ADDR_W=4, DEPTH=16; arm at cycle 0, first sample cycle 1)
REQ-023 Reset: reset 2 cycles mid-stimulus -> all outputs 0, state IDLE, no wr_en.
REQ-024 Rising: pre_len=4, level=0x80, ramp 0x00,+0x10 -> addr0..3 PRE, 0x80 at addr8, trig_addr=8, 20 writes, last addr 3, done=1 next cycle.
REQ-025 Falling wrap: pre_len=2, level=0x80, 30 samples 0x90 then 0x70 -> trig_addr=14, 14 post writes, last addr 11.
REQ-026 Force: pre_len=0, force_trig at cycle 3 -> trig_addr=2, 16 post writes, last addr 1; constant input never edge-triggers.
REQ-027 Handshake: arm during POST and DONE ignored; arm+rd_ack in DONE -> IDLE, no capture; rd_ack then arm -> new capture from addr 0.
REQ-028 Boundary: pre_len=15 -> exactly one post sample; reset during POST -> wr_en=0 next cycle, busy=0.

Source files
------------

// File: rtl/adc_cap_pkg.sv
// Types and default widths shared by the ADC trigger-capture block.
package adc_cap_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT_TRIG,
        POST,
        DONE
    } cap_state_e;

endpackage

// File: rtl/adc_trig_detect.sv
// Combinational level-crossing detector: rising or falling, unsigned compare.
module adc_trig_detect #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] prev,
    input  logic [DATA_W-1:0] cur,
    input  logic [DATA_W-1:0] level,
    input  logic              edge_sel,
    output logic              hit
);

    logic rise;
    logic fall;

    assign rise = (prev < level) && (cur >= level);
    assign fall = (prev > level) && (cur <= level);
    assign hit  = edge_sel ? fall : rise;

endmodule

// File: rtl/adc_trig_capture.sv
// Pre/post-trigger ADC capture engine driving the write port of an external
// circular buffer; the reader unwinds from trig_addr - pre_len.
module adc_trig_capture
    import adc_cap_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              arm,
    input  logic              force_trig,
    input  logic              trig_edge,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic              rd_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    cap_state_e        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  post_target;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] pre_len_reg;
    logic [ADDR_W-1:0] trig_addr_reg;
    logic [DATA_W-1:0] prev_reg;
    logic              prev_valid_reg;
    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [DATA_W-1:0] wr_data_reg;
    logic              edge_hit;
    logic              trig_now;
    logic              sampling;

    adc_trig_detect #(.DATA_W(DATA_W)) u_detect (
        .prev     (prev_reg),
        .cur      (adc_data),
        .level    (trig_level),
        .edge_sel (trig_edge),
        .hit      (edge_hit)
    );

    assign sampling    = (state_reg == PRE) || (state_reg == WAIT_TRIG) || (state_reg == POST);
    // The first sample of a capture has no predecessor, so only force_trig can fire on it.
    assign trig_now    = (state_reg == WAIT_TRIG) && (force_trig || (edge_hit && prev_valid_reg));
    assign cnt_inc     = cnt_reg + CNT_W'(1);
    assign post_target = DEPTH_C - CNT_W'(pre_len_reg);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (arm) begin
                    state_next = (pre_len != '0) ? PRE : WAIT_TRIG;
                    cnt_next   = '0;
                end
            end
            PRE: begin
                cnt_next = cnt_inc;
                if (cnt_inc == CNT_W'(pre_len_reg)) begin
                    state_next = WAIT_TRIG;
                    cnt_next   = '0;
                end
            end
            WAIT_TRIG: begin
                if (trig_now) begin
                    cnt_next   = CNT_W'(1);
                    state_next = (post_target == CNT_W'(1)) ? DONE : POST;
                end
            end
            POST: begin
                cnt_next = cnt_inc;
                if (cnt_inc == post_target) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (rd_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            addr_reg       <= '0;
            pre_len_reg    <= '0;
            trig_addr_reg  <= '0;
            prev_reg       <= '0;
            prev_valid_reg <= 1'b0;
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            wr_en_reg <= sampling;
            if (state_reg == IDLE && arm) begin
                addr_reg       <= '0;
                pre_len_reg    <= pre_len;
                prev_valid_reg <= 1'b0;
            end
            if (sampling) begin
                wr_addr_reg    <= addr_reg;
                wr_data_reg    <= adc_data;
                addr_reg       <= addr_reg + ADDR_W'(1);
                prev_reg       <= adc_data;
                prev_valid_reg <= 1'b1;
            end
            if (trig_now) begin
                trig_addr_reg <= addr_reg;
            end
        end
    end

    assign wr_en     = wr_en_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;
    assign trig_addr = trig_addr_reg;
    assign busy      = sampling;
    assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_adc_trig_capture.sv
// Bench for adc_trig_capture: table-driven scenarios, handshake/reset
// sequences and random captures checked against a sample-list model.
module tb_adc_trig_capture;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int NS    = 128;

    logic          clkin = 1'b0;
    logic          reset;
    logic [DW-1:0] adc_data;
    logic          arm;
    logic          force_trig;
    logic          trig_edge;
    logic [DW-1:0] trig_level;
    logic [AW-1:0] pre_len;
    logic          rd_ack;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] trig_addr;
    logic          busy;
    logic          done;

    adc_trig_capture #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clkin      (clkin),
        .reset      (reset),
        .adc_data   (adc_data),
        .arm        (arm),
        .force_trig (force_trig),
        .trig_edge  (trig_edge),
        .trig_level (trig_level),
        .pre_len    (pre_len),
        .rd_ack     (rd_ack),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .trig_addr  (trig_addr),
        .busy       (busy),
        .done       (done)
    );

    always #5 clkin = ~clkin;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] samp [NS];
    int            got_addr[$];
    int            got_data[$];
    int            exp_addr[$];
    int            exp_data[$];
    int            model_t;

    // Write-port monitor, sampled 1 time unit after each rising edge.
    always @(posedge clkin) begin
        #1;
        if (wr_en) begin
            got_addr.push_back(int'(wr_addr));
            got_data.push_back(int'(wr_data));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void fill_pattern(input int pat);
        for (int i = 0; i < NS; i++) begin
            case (pat)
                0:       samp[i] = DW'((i * 16) % 256);
                1:       samp[i] = (i < 30) ? 8'h90 : 8'h70;
                2:       samp[i] = 8'h80;
                default: samp[i] = DW'($urandom_range(0, 255));
            endcase
        end
    endfunction

    // Reference: find the trigger sample from the rules, then the capture is
    // simply samples 0 .. t+DEPTH-pre-1 written to address (index mod DEPTH).
    task automatic run_model(input int pre, input bit edg, input int lvl, input int fidx);
        int p, c;
        bit fire;
        model_t = -1;
        exp_addr.delete();
        exp_data.delete();
        for (int n = pre; n < NS && model_t < 0; n++) begin
            fire = (n == fidx);
            if (n >= 1) begin
                p = int'(samp[n-1]);
                c = int'(samp[n]);
                if (!edg && p < lvl && c >= lvl) fire = 1'b1;
                if (edg && p > lvl && c <= lvl)  fire = 1'b1;
            end
            if (fire) model_t = n;
        end
        if (model_t >= 0) begin
            for (int n = 0; n < model_t + DEPTH - pre; n++) begin
                exp_addr.push_back(n % DEPTH);
                exp_data.push_back(int'(samp[n]));
            end
        end
    endtask

    // Arms a capture at a negedge and streams samp[] until done (bounded).
    task automatic run_capture(input int pre, input bit edg, input int lvl,
                               input int fidx, input int arm_idx, input string tag);
        int k;
        got_addr.delete();
        got_data.delete();
        arm        = 1'b1;
        pre_len    = AW'(pre);
        trig_edge  = edg;
        trig_level = DW'(lvl);
        k = 0;
        while (k < NS - 1) begin
            @(negedge clkin);
            if (done) break;
            arm        = (k == arm_idx);
            adc_data   = samp[k];
            force_trig = (k == fidx);
            k++;
        end
        arm        = 1'b0;
        force_trig = 1'b0;
        chk({tag, " done_reached"}, int'(done), 1);
        chk({tag, " busy_in_done"}, int'(busy), 0);
        run_model(pre, edg, lvl, fidx);
        chk({tag, " write_count"}, got_addr.size(), exp_addr.size());
        if (model_t >= 0) chk({tag, " trig_addr"}, int'(trig_addr), model_t % DEPTH);
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            chk($sformatf("%s wr_addr[%0d]", tag, i), got_addr[i], exp_addr[i]);
            chk($sformatf("%s wr_data[%0d]", tag, i), got_data[i], exp_data[i]);
        end
        $display("capture %s: pre=%0d edge=%0d level=%0d writes=%0d trig_addr=%0d",
                 tag, pre, edg, lvl, got_addr.size(), trig_addr);
    endtask

    task automatic release_buffer();
        rd_ack = 1'b1;
        @(negedge clkin);
        rd_ack = 1'b0;
        chk("after_rd_ack done", int'(done), 0);
        @(negedge clkin);
    endtask

    typedef struct {
        string name;
        int    pre;
        bit    edg;
        int    lvl;
        int    pat;
        int    fidx;
        int    arm_idx;
        int    exp_trig;
        int    exp_writes;
        int    exp_last;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{"rising",      4, 1'b0, 'h80, 0, -1, -1,  8, 20,  3};
        vecs[1] = '{"falling_wrap",2, 1'b1, 'h80, 1, -1, -1, 14, 44, 11};
        vecs[2] = '{"force",       0, 1'b0, 'h80, 2,  2, -1,  2, 18,  1};
        vecs[3] = '{"pre15",      15, 1'b0, 'h80, 0, -1, -1,  8, 25,  8};
        vecs[4] = '{"arm_in_post", 4, 1'b0, 'h80, 0, -1, 12,  8, 20,  3};

        reset = 1'b1; adc_data = '0; arm = 1'b0; force_trig = 1'b0;
        trig_edge = 1'b0; trig_level = '0; pre_len = '0; rd_ack = 1'b0;
        repeat (3) @(negedge clkin);
        reset = 1'b0;
        chk("reset wr_en", int'(wr_en), 0);
        chk("reset wr_addr", int'(wr_addr), 0);
        chk("reset trig_addr", int'(trig_addr), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        @(negedge clkin);

        foreach (vecs[v]) begin
            fill_pattern(vecs[v].pat);
            run_capture(vecs[v].pre, vecs[v].edg, vecs[v].lvl, vecs[v].fidx,
                        vecs[v].arm_idx, vecs[v].name);
            chk({vecs[v].name, " tbl_trig_addr"}, int'(trig_addr), vecs[v].exp_trig);
            chk({vecs[v].name, " tbl_writes"}, got_addr.size(), vecs[v].exp_writes);
            if (got_addr.size() > 0)
                chk({vecs[v].name, " tbl_last_addr"}, got_addr[$], vecs[v].exp_last);
            chk({vecs[v].name, " tbl_post_writes"},
                (vecs[v].exp_last - vecs[v].exp_trig + DEPTH) % DEPTH + 1,
                DEPTH - vecs[v].pre);
            release_buffer();
        end

        // Handshake: arm alone in DONE ignored, arm+rd_ack returns to IDLE only.
        fill_pattern(0);
        run_capture(4, 1'b0, 'h80, -1, -1, "handshake");
        arm = 1'b1;
        @(negedge clkin);
        chk("arm_in_done done", int'(done), 1);
        chk("arm_in_done wr_en", int'(wr_en), 0);
        rd_ack = 1'b1;
        @(negedge clkin);
        arm = 1'b0; rd_ack = 1'b0;
        chk("arm_ack done", int'(done), 0);
        chk("arm_ack busy", int'(busy), 0);
        repeat (2) @(negedge clkin);
        chk("arm_ack no_capture busy", int'(busy), 0);
        chk("arm_ack no_capture wr_en", int'(wr_en), 0);
        fill_pattern(0);
        run_capture(4, 1'b0, 'h80, -1, -1, "rearm");
        release_buffer();

        // Reset during POST.
        fill_pattern(2);
        pre_len = '0; trig_edge = 1'b0; trig_level = 8'h80;
        arm = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clkin);
            arm = 1'b0;
            adc_data = samp[k];
            force_trig = (k == 3);
        end
        force_trig = 1'b0;
        chk("post busy", int'(busy), 1);
        chk("post trig_addr", int'(trig_addr), 3);
        reset = 1'b1;
        @(negedge clkin);
        chk("reset_in_post wr_en", int'(wr_en), 0);
        chk("reset_in_post busy", int'(busy), 0);
        @(negedge clkin);
        reset = 1'b0;
        chk("reset_in_post trig_addr", int'(trig_addr), 0);
        chk("reset_in_post wr_addr", int'(wr_addr), 0);
        chk("reset_in_post wr_data", int'(wr_data), 0);
        chk("reset_in_post done", int'(done), 0);
        @(negedge clkin);
        chk("idle_after_reset wr_en", int'(wr_en), 0);

        // Random captures against the model.
        for (int r = 0; r < 12; r++) begin
            int pre, lvl, fidx;
            bit edg;
            fill_pattern(3);
            pre  = $urandom_range(0, 15);
            edg  = 1'($urandom_range(0, 1));
            lvl  = $urandom_range(0, 255);
            fidx = $urandom_range(pre, 90);
            run_capture(pre, edg, lvl, fidx, -1, $sformatf("rand%0d", r));
            release_buffer();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
